async_fifo_write_ctrl_gen2: RTL

Parametrised write-side controller for the dual-clock flop FIFO, running entirely in the write clock domain. Owns the binary write pointer and the registered Gray-code write pointer. Contains its own multi-stage synchroniser for the incoming read Gray pointer and produces registered full, almost-full, fill-level and sticky overflow status. Sits between the write-side client and the flop memory array; the read-side controller consumes write_gcode_ptr.

---
 rtl/async_fifo_write_ctrl_gen2.sv | 92 +++++++++
 1 files changed

// File: rtl/async_fifo_write_ctrl_gen2.sv
// Write-side controller for the dual-clock flop FIFO: binary/Gray write pointer,
// read-pointer synchroniser, and registered full/almost-full/level/overflow status.
module async_fifo_write_ctrl_gen2 #(
  parameter int unsigned ADDR_BITS    = 3,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_push,
  input  logic [ADDR_BITS:0]   read_gcode_ptr,
  input  logic                 clear_overflow,
  output logic                 write_mem_en,
  output logic [ADDR_BITS-1:0] write_memory_addr,
  output logic [ADDR_BITS:0]   write_gcode_ptr,
  output logic                 fifo_full,
  output logic                 fifo_almost_full,
  output logic [ADDR_BITS:0]   fifo_wr_level,
  output logic                 fifo_overflow
);

  localparam int unsigned PW = ADDR_BITS + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rptr_sync;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] level_next;
  logic          push_ok;

  // Strobe is held low while reset is asserted so no memory write can slip through.
  always_comb begin
    push_ok           = fifo_push & ~fifo_full & ~reset;
    write_mem_en      = push_ok;
    write_memory_addr = wbin[ADDR_BITS-1:0];
  end

  always_comb begin
    wbin_next = wbin + {{(PW-1){1'b0}}, push_ok};
    gray_next = wbin_next ^ (wbin_next >> 1);
  end

  always_comb begin
    rptr_sync = sync_q[SYNC_STAGES-1];
    rbin_sync = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin_sync[i] = ^(rptr_sync >> i);
    end
    full_gray  = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};
    level_next = wbin_next - rbin_sync;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= read_gcode_ptr;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin             <= '0;
      write_gcode_ptr  <= '0;
      fifo_full        <= 1'b0;
      fifo_almost_full <= 1'b0;
      fifo_wr_level    <= '0;
      fifo_overflow    <= 1'b0;
    end else begin
      wbin             <= wbin_next;
      write_gcode_ptr  <= gray_next;
      fifo_full        <= (gray_next == full_gray);
      fifo_wr_level    <= level_next;
      fifo_almost_full <= (level_next >= AFULL_LVL);
      if (fifo_push & fifo_full) begin
        fifo_overflow <= 1'b1;
      end else if (clear_overflow) begin
        fifo_overflow <= 1'b0;
      end
    end
  end

endmodule
